// File: rtl/mcu_pkg.sv
// mcu_pkg: shared types and defaults for the main-control dispatcher.
//   N_UNITS_DEF   default number of order units / start-pulse lines
//   TIMEOUT_DEF   default WAIT cycles without ep before abort
//   TO_W_DEF      default timeout counter width (2**TO_W > TIMEOUT)
//   unit_id_t     4-bit order-unit index
//   dispatch_state_t  IDLE / ISSUE / WAIT / DONE
package mcu_pkg;

    localparam int unsigned N_UNITS_DEF = 12;
    localparam int unsigned TIMEOUT_DEF = 1023;
    localparam int unsigned TO_W_DEF    = 10;
    localparam int unsigned UNIT_W      = 4;

    typedef logic [UNIT_W-1:0] unit_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } dispatch_state_t;

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mcu_timeout_timer.sv
// mcu_timeout_timer: TO_W-bit up-counter guarding the WAIT state.
//   clk        system clock
//   rst        synchronous active-high reset (count cleared)
//   clr_i      clear count to zero (priority over en_i)
//   en_i       increment count by one
//   expired_o  count has reached TIMEOUT-1, i.e. the next increment would
//              complete TIMEOUT counted cycles
module mcu_timeout_timer
    import mcu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_W    = TO_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/mcu_dispatch.sv
// mcu_dispatch: main-control initiator for the order-unit start/end pulse
// protocol. Accepts one decoded order, fires a one-cycle one-hot start pulse,
// waits for the merged end pulse, then reports done with the sign-insertion
// flag. A stalled unit is aborted after TIMEOUT WAIT cycles.
//   clk, rst       clock, synchronous active-high reset
//   order_valid/order_ready/order_unit   order handshake from the decoder
//   sp             one-hot start pulses to units 0..N_UNITS-1
//   ep, ccu_ones   merged end pulse / sign-insertion pulse from the units
//   busy, done     activity and one-cycle completion pulse
//   ones_flag      ccu_ones seen during the order (valid with done)
//   err_timeout, err_badunit   one-cycle error pulses
//   spurious_cnt   ep pulses seen outside WAIT
// Build option: define MCU_SPURIOUS_EP_EN to build the spurious-ep counter;
// otherwise spurious_cnt is tied to zero.
module mcu_dispatch
    import mcu_pkg::*;
#(
    parameter int unsigned N_UNITS = N_UNITS_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_W    = TO_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               order_valid,
    output logic               order_ready,
    input  logic [UNIT_W-1:0]  order_unit,
    output logic [N_UNITS-1:0] sp,
    input  logic               ep,
    input  logic               ccu_ones,
    output logic               busy,
    output logic               done,
    output logic               ones_flag,
    output logic               err_timeout,
    output logic               err_badunit,
    output logic [7:0]         spurious_cnt
);

    dispatch_state_t state_q, state_d;
    unit_id_t        unit_q, unit_d;
    logic            ones_q, ones_d;
    logic            err_to_q, err_to_d;
    logic            err_bad_q, err_bad_d;
    logic            tmr_clr, tmr_en, tmr_exp;
    logic            unit_ok;

    assign unit_ok = (32'(order_unit) < N_UNITS);

    mcu_timeout_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_exp)
    );

    always_comb begin
        state_d   = state_q;
        unit_d    = unit_q;
        ones_d    = ones_q;
        err_to_d  = 1'b0;
        err_bad_d = 1'b0;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (order_valid) begin
                    if (unit_ok) begin
                        unit_d  = order_unit;
                        ones_d  = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        err_bad_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                tmr_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (ccu_ones) begin
                    ones_d = 1'b1;
                end
                // ep takes priority over an expiring timer in the same cycle.
                if (ep) begin
                    state_d = DONE;
                end else if (tmr_exp) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            unit_q    <= '0;
            ones_q    <= 1'b0;
            err_to_q  <= 1'b0;
            err_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            unit_q    <= unit_d;
            ones_q    <= ones_d;
            err_to_q  <= err_to_d;
            err_bad_q <= err_bad_d;
        end
    end

    always_comb begin
        sp = '0;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            sp[i] = (state_q == ISSUE) && (unit_q == unit_id_t'(i));
        end
    end

    assign order_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign ones_flag   = ones_q;
    assign err_timeout = err_to_q;
    assign err_badunit = err_bad_q;

`ifdef MCU_SPURIOUS_EP_EN
    logic [7:0] spur_q;

    // Any ep outside WAIT is unsolicited.
    always_ff @(posedge clk) begin
        if (rst) begin
            spur_q <= '0;
        end else if (ep && (state_q != WAIT)) begin
            spur_q <= sat_inc8(spur_q);
        end
    end

    assign spurious_cnt = spur_q;
`else
    assign spurious_cnt = '0;
`endif

endmodule

// File: tb/tb_mcu_dispatch.sv
// tb_mcu_dispatch: self-checking bench for mcu_dispatch. Each scenario task
// drives stimulus on the falling edge and checks outputs one half-cycle after
// the DUT's rising edge against expectations derived from the protocol's
// cycle timing (accept, sp next cycle, done one cycle after ep).
// Build option: MCU_SPURIOUS_EP_EN enables the spurious-ep expectations.
module tb_mcu_dispatch;

    localparam int unsigned NU  = 12;
    localparam int unsigned TMO = 1023;
    localparam int unsigned TW  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          order_valid;
    logic          order_ready;
    logic [3:0]    order_unit;
    logic [NU-1:0] sp;
    logic          ep;
    logic          ccu_ones;
    logic          busy;
    logic          done;
    logic          ones_flag;
    logic          err_timeout;
    logic          err_badunit;
    logic [7:0]    spurious_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_spur = 0;

    always #5 clk = ~clk;

    mcu_dispatch #(
        .N_UNITS (NU),
        .TIMEOUT (TMO),
        .TO_W    (TW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .order_valid  (order_valid),
        .order_ready  (order_ready),
        .order_unit   (order_unit),
        .sp           (sp),
        .ep           (ep),
        .ccu_ones     (ccu_ones),
        .busy         (busy),
        .done         (done),
        .ones_flag    (ones_flag),
        .err_timeout  (err_timeout),
        .err_badunit  (err_badunit),
        .spurious_cnt (spurious_cnt)
    );

    // Model of the spurious counter: one ep sampled outside WAIT.
    task automatic note_stray_ep();
`ifdef MCU_SPURIOUS_EP_EN
        if (exp_spur < 255) exp_spur++;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; order_valid = 1'b1; order_unit = 4'd5; ep = 1'b1; ccu_ones = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; order_valid = 1'b0; ep = 1'b0; ccu_ones = 1'b0;
        exp_spur = 0;
        n_checks++;
        if ({order_ready, busy, done, ones_flag, err_timeout, err_badunit} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {order_ready, busy, done, ones_flag, err_timeout, err_badunit});
        end
        n_checks++;
        if (sp !== '0) begin
            n_fail++; $display("FAIL reset_sp: got %h expected 0", sp);
        end
        n_checks++;
        if (spurious_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_spur: got %0d expected 0", spurious_cnt);
        end
    endtask

    // One complete order; entered and left on a falling edge in IDLE.
    // d: ep arrives d cycles after the sp cycle (d >= 1).
    // ones_mode: 0 none, 1 random, 2 single mid-WAIT pulse, 3 only on ep cycle.
    task automatic test_order(input int u, input int d, input int ones_mode);
        logic [NU-1:0] exp_sp;
        logic          exp_ones;
        exp_sp = '0;
        exp_sp[u] = 1'b1;
        exp_ones = 1'b0;
        n_checks++;
        if (order_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL order_idle u=%0d: got ready=%b busy=%b done=%b expected 1 0 0",
                     u, order_ready, busy, done);
        end
        order_valid = 1'b1; order_unit = 4'(u); ep = 1'b0; ccu_ones = 1'b0;
        @(negedge clk);
        // ISSUE cycle: decoder may keep valid high, ccu_ones here must not count.
        order_valid = 1'($urandom_range(0, 1));
        ccu_ones    = 1'($urandom_range(0, 1));
        n_checks++;
        if (sp !== exp_sp || order_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL order_sp u=%0d: got sp=%h ready=%b busy=%b expected sp=%h 0 1",
                     u, sp, order_ready, busy, exp_sp);
        end
        for (int c = 1; c <= d; c++) begin
            @(negedge clk);
            ep = (c == d);
            case (ones_mode)
                1:       ccu_ones = 1'($urandom_range(0, 1));
                2:       ccu_ones = (c == (d + 1) / 2);
                3:       ccu_ones = (c == d);
                default: ccu_ones = 1'b0;
            endcase
            exp_ones = exp_ones | ccu_ones;
            n_checks++;
            if (sp !== '0 || done !== 1'b0 || busy !== 1'b1 || err_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL order_wait u=%0d c=%0d: got sp=%h done=%b busy=%b to=%b expected 0 0 1 0",
                         u, c, sp, done, busy, err_timeout);
            end
        end
        @(negedge clk);
        ep = 1'b0; order_valid = 1'b0;
        ccu_ones = 1'($urandom_range(0, 1));
        n_checks++;
        if (done !== 1'b1 || ones_flag !== exp_ones) begin
            n_fail++;
            $display("FAIL order_done u=%0d: got done=%b ones=%b expected 1 %b",
                     u, done, ones_flag, exp_ones);
        end
        n_checks++;
        if (sp !== '0 || order_ready !== 1'b0 || err_timeout !== 1'b0 || err_badunit !== 1'b0) begin
            n_fail++;
            $display("FAIL order_done_side u=%0d: got sp=%h ready=%b to=%b bad=%b expected 0 0 0 0",
                     u, sp, order_ready, err_timeout, err_badunit);
        end
        @(negedge clk);
        ccu_ones = 1'b0;
        n_checks++;
        if (done !== 1'b0 || spurious_cnt !== 8'(exp_spur)) begin
            n_fail++;
            $display("FAIL order_after u=%0d: got done=%b spur=%0d expected 0 %0d",
                     u, done, spurious_cnt, exp_spur);
        end
    endtask

    task automatic test_badunit(input int u);
        order_valid = 1'b1; order_unit = 4'(u);
        @(negedge clk);
        order_valid = 1'b0;
        n_checks++;
        if (err_badunit !== 1'b1 || sp !== '0 || order_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL badunit u=%0d: got bad=%b sp=%h ready=%b busy=%b expected 1 0 1 0",
                     u, err_badunit, sp, order_ready, busy);
        end
        @(negedge clk);
        n_checks++;
        if (err_badunit !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL badunit_end u=%0d: got bad=%b busy=%b done=%b expected 0 0 0",
                     u, err_badunit, busy, done);
        end
    endtask

    // No ep: error pulse must appear TMO+1 cycles after the sp cycle.
    task automatic test_timeout(input int u);
        logic [NU-1:0] exp_sp;
        exp_sp = '0;
        exp_sp[u] = 1'b1;
        order_valid = 1'b1; order_unit = 4'(u); ep = 1'b0; ccu_ones = 1'b0;
        @(negedge clk);
        order_valid = 1'b0;
        n_checks++;
        if (sp !== exp_sp) begin
            n_fail++; $display("FAIL timeout_sp: got %h expected %h", sp, exp_sp);
        end
        for (int c = 1; c <= int'(TMO); c++) begin
            @(negedge clk);
            n_checks++;
            if (err_timeout !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_wait c=%0d: got to=%b done=%b busy=%b expected 0 0 1",
                         c, err_timeout, done, busy);
            end
        end
        @(negedge clk);
        n_checks++;
        if (err_timeout !== 1'b1 || done !== 1'b0 || order_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got to=%b done=%b ready=%b busy=%b expected 1 0 1 0",
                     err_timeout, done, order_ready, busy);
        end
        @(negedge clk);
        n_checks++;
        if (err_timeout !== 1'b0 || done !== 1'b0 || order_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_after: got to=%b done=%b ready=%b expected 0 0 1",
                     err_timeout, done, order_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            test_order(int'($urandom_range(0, NU - 1)), 1, 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                test_badunit(int'($urandom_range(NU, 15)));
            end else begin
                test_order(int'($urandom_range(0, NU - 1)), int'($urandom_range(1, 7)), 1);
            end
        end
    endtask

    task automatic test_rst_midwait();
        order_valid = 1'b1; order_unit = 4'd9; ep = 1'b0; ccu_ones = 1'b0;
        @(negedge clk);
        order_valid = 1'b0;
        @(negedge clk);
        ccu_ones = 1'b1;
        @(negedge clk);
        ccu_ones = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        exp_spur = 0;
        n_checks++;
        if ({order_ready, busy, done, ones_flag, err_timeout, err_badunit} !== 6'b100000
            || sp !== '0 || spurious_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_midwait: got flags=%b sp=%h spur=%0d expected 100000 0 0",
                     {order_ready, busy, done, ones_flag, err_timeout, err_badunit},
                     sp, spurious_cnt);
        end
        rst = 1'b0; ep = 1'b1;
        note_stray_ep();
        @(negedge clk);
        ep = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sp !== '0 || spurious_cnt !== 8'(exp_spur)) begin
            n_fail++;
            $display("FAIL rst_late_ep: got done=%b busy=%b sp=%h spur=%0d expected 0 0 0 %0d",
                     done, busy, sp, spurious_cnt, exp_spur);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_done: got done=%b to=%b expected 0 0", done, err_timeout);
        end
    endtask

    task automatic test_spurious_sat();
        for (int i = 1; i <= 300; i++) begin
            ep = 1'b1;
            note_stray_ep();
            @(negedge clk);
            ep = 1'b0;
            @(negedge clk);
            if (i == 100 || i == 254 || i == 300) begin
                n_checks++;
                if (spurious_cnt !== 8'(exp_spur) || busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL spurious i=%0d: got cnt=%0d busy=%b done=%b expected %0d 0 0",
                             i, spurious_cnt, busy, done, exp_spur);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; order_valid = 1'b0; order_unit = '0; ep = 1'b0; ccu_ones = 1'b0;
        test_reset();
        test_order(5, 3, 0);
        test_badunit(13);
        test_timeout(0);
        test_order(11, int'(TMO), 1);   // ep on the last WAIT cycle beats the timeout
        test_order(3, 4, 2);
        test_order(4, 4, 0);
        test_order(7, 2, 3);
        test_back_to_back();
        test_random();
        test_rst_midwait();
        test_spurious_sat();
        test_order(1, 1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
